// File: rtl/barramento_arbitrado.sv
// Registered, arbitrated shared bus: one writer per cycle wins by round-robin
// or fixed priority, and every enabled reader captures the word a cycle later.
module barramento_arbitrado #(
  parameter int NUM_PORTS     = 6,
  parameter int LARGURA       = 8,
  parameter int PRIORITY_MODE = 0,
  parameter int CNT_W         = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         wr_req,
  input  logic [NUM_PORTS*LARGURA-1:0] wr_data,
  input  logic [NUM_PORTS-1:0]         rd_en,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [LARGURA-1:0]           bus_data,
  output logic                         bus_valid,
  output logic [NUM_PORTS*LARGURA-1:0] rd_data,
  output logic [NUM_PORTS-1:0]         rd_valid,
  output logic [CNT_W-1:0]             contention_cnt
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [PTR_W-1:0]             r_last;
  logic [NUM_PORTS-1:0]         r_grant;
  logic [LARGURA-1:0]           r_bus_data;
  logic                         r_bus_valid;
  logic [NUM_PORTS*LARGURA-1:0] r_rd_data;
  logic [NUM_PORTS-1:0]         r_rd_valid;
  logic [CNT_W-1:0]             r_cnt;

  logic [PTR_W-1:0] w_winner;
  logic             w_found;
  int               w_scan_idx;
  logic             w_any;
  logic             w_multi;

  assign w_any   = |wr_req;
  // Clearing the lowest set bit leaves something only when two or more request.
  assign w_multi = |(wr_req & (wr_req - NUM_PORTS'(1)));

  always_comb begin
    w_winner   = '0;
    w_found    = 1'b0;
    w_scan_idx = 0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (wr_req[PTR_W'(i)]) w_winner = PTR_W'(i);
      end
    end else begin
      // Scan starting just after the previous winner, wrapping modulo NUM_PORTS.
      for (int k = 1; k <= NUM_PORTS; k++) begin
        w_scan_idx = int'(r_last) + k;
        if (w_scan_idx >= NUM_PORTS) w_scan_idx = w_scan_idx - NUM_PORTS;
        if (!w_found && wr_req[PTR_W'(w_scan_idx)]) begin
          w_winner = PTR_W'(w_scan_idx);
          w_found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= PTR_W'(NUM_PORTS - 1);
      r_grant     <= '0;
      r_bus_data  <= '0;
      r_bus_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_any) begin
        r_grant     <= NUM_PORTS'(1) << w_winner;
        r_bus_data  <= wr_data[int'(w_winner)*LARGURA +: LARGURA];
        r_bus_valid <= 1'b1;
        if (PRIORITY_MODE == 0) r_last <= w_winner;
      end else begin
        r_grant     <= '0;
        r_bus_valid <= 1'b0;
      end
      if (w_multi && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Readers sample the word currently on the bus, so capture trails the write by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (r_bus_valid && rd_en[j]) r_rd_data[j*LARGURA +: LARGURA] <= r_bus_data;
        r_rd_valid[j] <= r_bus_valid && rd_en[j];
      end
    end
  end

  assign grant          = r_grant;
  assign bus_data       = r_bus_data;
  assign bus_valid      = r_bus_valid;
  assign rd_data        = r_rd_data;
  assign rd_valid       = r_rd_valid;
  assign contention_cnt = r_cnt;

endmodule
